mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage, directly downstream of the execute stage. It takes the ALU result (the address or the pass-through value) and the store data from the EX/MEM register. It drives the data-memory bus with a request/grant/response handshake and performs byte-lane steering, load sign/zero extension and alignment checks. The result is delivered to the MEM/WB register through a valid/ready handshake, and the hazard unit is stalled while an access is outstanding.

## Interface
- MAX_WAIT, 255: cycles an access may spend in REQ+WAIT before it is aborted with a timeout.
- clk  in  1  single clock, all state rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM entry valid.
- in_ready  out  1  stage accepts the entry this cycle.
- in_addr  in  32  ALU result; address for memory ops, writeback value otherwise.
- in_sd  in  32  store data (rs2).
- in_load, in_store  in  1 each  op class; both 0 means non-memory op; both 1 never driven.
- in_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- in_rd  in  5  destination register.
- in_reg_write  in  1  writeback enable.
- stall  out  1  equals in_valid & ~in_ready.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  {in_addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables; 0000 on loads.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data.
- out_valid  out  1  MEM/WB entry valid.
- out_ready  in  1  MEM/WB accepts.
- out_data  out  32  writeback value.
- out_rd  out  5  destination register.
- out_reg_write  out  1  writeback enable; forced 0 when out_exc is 1.
- out_exc  out  1  exception flag.
- out_exc_cause  out  2  01 misaligned load, 10 misaligned store, 11 bus timeout.

## Operation
- FSM states:
  - IDLE: the only state that can accept an entry.
  - REQ: dmem_req=1. Address, we, be and wdata come from registered copies of the accepted entry and are held stable until grant.
  - WAIT: load only; waiting for dmem_rvalid.
- in_ready = (state==IDLE) & (~out_valid | out_ready).
- Invariant: out_valid=0 whenever the state is not IDLE.
- Accepting a non-memory op loads the output register next edge: out_data=in_addr, rd and reg_write passed through.
- Alignment check at accept:
  - A halfword is misaligned when addr[0]=1.
  - A word is misaligned when addr[1:0]≠00.
  - A misaligned op issues no bus request. The output loads next edge with out_exc=1, the matching cause, out_reg_write=0 and out_data=in_addr.
- Accepting an aligned memory op enters REQ.
- REQ with dmem_gnt:
  - Store: the output loads with out_data=0 and reg_write as given, then IDLE.
  - Load: enter WAIT.
- WAIT with dmem_rvalid: the output loads the formatted data, then IDLE.
- dmem_rvalid in any state other than WAIT is ignored.
- Store steering, with byte offset off = addr[1:0]:
  - SB: wdata={4{sd[7:0]}}, be=0001<<off.
  - SH: wdata={2{sd[15:0]}}, be=0011 (off=0) or 1100 (off=2).
  - SW: wdata=sd, be=1111.
- Load formatting:
  - B/BU: lane rdata[8*off+:8], sign- or zero-extended.
  - H/HU: rdata[16*off[1]+:16], sign- or zero-extended.
  - W: rdata unchanged.
- Timeout counter:
  - Cleared on entry to REQ and incremented each cycle in REQ or WAIT.
  - If the completing event (gnt in REQ, rvalid in WAIT) is absent on the cycle where the counter equals MAX_WAIT-1, the access is aborted: output exception cause 11, dmem_req drops, return to IDLE.
- Output register holds all fields while out_valid & ~out_ready.

## Timing
- Reset values: state IDLE; out_valid, out_data, out_rd, out_reg_write, out_exc, out_exc_cause and the counter all 0.
- Resulting outputs during reset: dmem_req=0, dmem_be=0000, in_ready=1.
- Reset asserted mid-access: dmem_req falls immediately (asynchronously) and any in-flight result is discarded.
- Latencies, with accept at edge N:
  - Non-memory or misaligned op: out_valid from cycle N+1.
  - Store: dmem_req high from N+1; grant in cycle N+k gives out_valid at N+k+1.
  - Load: earliest rvalid is the cycle after grant, so out_valid is at N+3 at the earliest.
- Back-to-back non-memory ops with out_ready=1 sustain one result per cycle.
- Simultaneous out_ready and accept: the old entry drains and the new one loads on the same edge.
- Grant and timeout in the same cycle: the grant wins.

## Test plan
- Non-memory op stream: 4 ops with in_addr=1,2,3,4, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles; stall never asserted.
- SB to 0x1003 with sd=0xAB, gnt on first REQ cycle -> dmem_addr=0x1000, be=1000, wdata=0xABABABAB; out_valid 2 cycles after accept.
- LH to 0x2002 with rdata=0x8001_0000, rvalid 3 cycles after gnt -> out_data=0xFFFF8001. Same access as LHU -> 0x00008001. stall held high for the whole access.
- LW to 0x3001 -> no dmem_req, out_exc=1, cause=01, out_reg_write=0, one cycle after accept.
- Load never answered, MAX_WAIT=8 -> dmem_req for exactly 8 cycles total in REQ+WAIT, then cause=11; a later stray rvalid is ignored.
- out_ready held low for 5 cycles with out_valid=1 -> all output fields stable; in_ready=0; next op accepted on the cycle out_ready rises. rst pulsed during WAIT -> all outputs return to their reset values.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave):
// request/grant for the address phase, rvalid for returning load data.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte-lane steering, load extension, alignment
// checks and a bounded bus handshake between EX/MEM and MEM/WB.
module mem_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_sd,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_size,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        stall,
  mem_stage_if.master bus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_exc,
  output logic [1:0]  out_exc_cause
);

  // Counter only needs to reach MAX_WAIT-1; the access always ends there.
  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t          state, state_nx;
  logic [31:0]     r_addr, r_wdata;
  logic [3:0]      r_be;
  logic            r_we;
  logic [2:0]      r_size;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic [CW-1:0]   cnt;

  logic            accept, is_mem, misaligned, start, timeout;
  logic [31:0]     st_wdata;
  logic [3:0]      st_be;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_data;

  logic            res_load;
  logic [31:0]     res_data;
  logic [4:0]      res_rd;
  logic            res_rw;
  logic            res_exc;
  logic [1:0]      res_cause;

  assign in_ready   = (state == IDLE) & (~out_valid | out_ready);
  assign stall      = in_valid & ~in_ready;
  assign accept     = in_valid & in_ready;
  assign is_mem     = in_load | in_store;
  assign misaligned = ((in_size[1:0] == 2'b01) & in_addr[0])
                    | (in_size[1] & (in_addr[1:0] != 2'b00));
  assign start      = accept & is_mem & ~misaligned;
  assign timeout    = (cnt == CW'(MAX_WAIT - 1));

  assign bus.dmem_req   = (state == REQ);
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = {r_addr[31:2], 2'b00};
  assign bus.dmem_wdata = r_wdata;
  assign bus.dmem_be    = (state == REQ) ? r_be : 4'b0000;

  always_comb begin
    st_wdata = in_sd;
    st_be    = 4'b1111;
    case (in_size[1:0])
      2'b00: begin
        st_wdata = {4{in_sd[7:0]}};
        st_be    = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_sd[15:0]}};
        st_be    = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!in_store) st_be = 4'b0000;
  end

  assign ld_byte = bus.dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign ld_half = r_addr[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

  // size[2] marks the unsigned variants, which suppress sign extension.
  always_comb begin
    case (r_size[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ~r_size[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~r_size[2]}}, ld_half};
      default: ld_data = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_nx  = state;
    res_load  = 1'b0;
    res_data  = '0;
    res_rd    = r_rd;
    res_rw    = 1'b0;
    res_exc   = 1'b0;
    res_cause = 2'b00;
    case (state)
      IDLE: begin
        if (accept) begin
          res_rd   = in_rd;
          res_data = in_addr;
          if (!is_mem) begin
            res_load = 1'b1;
            res_rw   = in_reg_write;
          end else if (misaligned) begin
            res_load  = 1'b1;
            res_exc   = 1'b1;
            res_cause = in_load ? 2'b01 : 2'b10;
          end else begin
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        // A grant on the last allowed cycle still completes the access.
        if (bus.dmem_gnt) begin
          if (r_we) begin
            res_load = 1'b1;
            res_rw   = r_reg_write;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT;
          end
        end else if (timeout) begin
          res_load  = 1'b1;
          res_exc   = 1'b1;
          res_cause = 2'b11;
          res_data  = r_addr;
          state_nx  = IDLE;
        end
      end
      WAIT: begin
        if (bus.dmem_rvalid) begin
          res_load = 1'b1;
          res_data = ld_data;
          res_rw   = r_reg_write;
          state_nx = IDLE;
        end else if (timeout) begin
          res_load  = 1'b1;
          res_exc   = 1'b1;
          res_cause = 2'b11;
          res_data  = r_addr;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_we        <= 1'b0;
      r_size      <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        r_addr      <= in_addr;
        r_wdata     <= st_wdata;
        r_be        <= st_be;
        r_we        <= in_store;
        r_size      <= in_size;
        r_rd        <= in_rd;
        r_reg_write <= in_reg_write;
        cnt         <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // A new result may load on the same edge the previous one drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_exc       <= 1'b0;
      out_exc_cause <= 2'b00;
    end else if (res_load) begin
      out_valid     <= 1'b1;
      out_data      <= res_data;
      out_rd        <= res_rd;
      out_reg_write <= res_rw;
      out_exc       <= res_exc;
      out_exc_cause <= res_cause;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// compared against a behavioural model of the stage's result and bus beat.
module tb_mem_stage;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_load, in_store, in_reg_write, stall;
  logic [31:0] in_addr, in_sd;
  logic [2:0]  in_size;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_reg_write, out_exc;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  out_exc_cause;

  int vectors = 0;
  int miscompares = 0;

  mem_stage_if bus ();

  mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_sd        (in_sd),
    .in_load      (in_load),
    .in_store     (in_store),
    .in_size      (in_size),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .stall        (stall),
    .bus          (bus),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .out_reg_write(out_reg_write),
    .out_exc      (out_exc),
    .out_exc_cause(out_exc_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        exc;
    logic [1:0]  cause;
    logic [15:0] lat;
    logic [15:0] req_cycles;
    logic [15:0] stall_cycles;
    logic        got;
    logic        saw_req;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  bbe;
    logic        bwe;
  } obs_t;

  typedef struct packed {
    logic [31:0] data;
    logic        rw;
    logic        exc;
    logic [1:0]  cause;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        mem;
  } exp_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the stage must produce, derived from the op rules alone.
  function automatic exp_t model(input logic ld, input logic st, input logic [2:0] sz,
                                 input logic [31:0] addr, input logic [31:0] sd,
                                 input logic [31:0] rdata, input logic rw);
    exp_t e;
    int unsigned off, nb, v;
    e   = '0;
    off = 32'(addr[1:0]);
    nb  = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    if (!ld && !st) begin
      e.data = addr;
      e.rw   = rw;
    end else if ((addr % nb) != 0) begin
      e.exc   = 1'b1;
      e.cause = ld ? 2'd1 : 2'd2;
      e.data  = addr;
    end else if (st) begin
      e.mem   = 1'b1;
      e.rw    = rw;
      e.data  = 32'd0;
      e.be    = 4'(((1 << nb) - 1) << off);
      e.wdata = (nb == 1) ? 32'(sd[7:0]) * 32'h0101_0101 :
                (nb == 2) ? 32'(sd[15:0]) * 32'h0001_0001 : sd;
    end else begin
      e.mem = 1'b1;
      e.rw  = rw;
      v = rdata >> (8 * off);
      if (nb == 1) begin
        v = v % 256;
        if (!sz[2] && v >= 128) v = v - 256;
      end else if (nb == 2) begin
        v = v % 65536;
        if (!sz[2] && v >= 32768) v = v - 65536;
      end
      e.data = v;
    end
    return e;
  endfunction

  // Presents one op, plays the memory side, and reports what was observed.
  task automatic drive_op(input logic ld, input logic st, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input logic rw, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata, input logic hold, output obs_t o);
    int c, gc, nreq;
    logic granted;
    o = '0;
    granted = 1'b0;
    gc = 0;
    nreq = 0;
    in_load = ld; in_store = st; in_size = sz; in_addr = addr; in_sd = sd;
    in_rd = rd; in_reg_write = rw; in_valid = 1'b1;
    bus.dmem_rdata = rdata;
    #1;
    c = 0;
    while (!in_ready && c < 50) begin
      step();
      c++;
    end
    step();
    if (hold) begin
      in_load = 1'b0; in_store = 1'b0; in_addr = 32'h0000_0F0F; in_rd = 5'd9; in_reg_write = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    for (c = 1; c <= 400; c++) begin
      if (out_valid) begin
        o.got = 1'b1; o.lat = 16'(c); o.data = out_data; o.rd = out_rd;
        o.rw = out_reg_write; o.exc = out_exc; o.cause = out_exc_cause;
        break;
      end
      if (stall) o.stall_cycles++;
      bus.dmem_gnt = 1'b0;
      bus.dmem_rvalid = 1'b0;
      if (bus.dmem_req) begin
        if (!o.saw_req) begin
          o.saw_req = 1'b1; o.baddr = bus.dmem_addr; o.bwdata = bus.dmem_wdata;
          o.bbe = bus.dmem_be; o.bwe = bus.dmem_we;
        end
        if (nreq == gnt_dly) begin
          bus.dmem_gnt = 1'b1;
          granted = 1'b1;
          gc = c;
        end
        nreq++;
      end
      if (granted && rv_dly >= 0 && c == gc + rv_dly) bus.dmem_rvalid = 1'b1;
      step();
    end
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    o.req_cycles = 16'(nreq);
    vectors++; if (!o.got) begin miscompares++; $display("[TB] FAIL op_complete: no out_valid within 400 cycles (addr %h)", addr); end
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (out_valid !== 1'b0)   begin miscompares++; $display("[TB] FAIL rst_out_valid got %b exp 0", out_valid); end
    vectors++; if (out_data !== 32'd0)   begin miscompares++; $display("[TB] FAIL rst_out_data got %h exp 0", out_data); end
    vectors++; if (out_rd !== 5'd0)      begin miscompares++; $display("[TB] FAIL rst_out_rd got %h exp 0", out_rd); end
    vectors++; if (out_reg_write !== 1'b0 || out_exc !== 1'b0 || out_exc_cause !== 2'd0)
      begin miscompares++; $display("[TB] FAIL rst_out_flags got rw=%b exc=%b cause=%b exp 0", out_reg_write, out_exc, out_exc_cause); end
    vectors++; if (bus.dmem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req got %b exp 0", bus.dmem_req); end
    vectors++; if (bus.dmem_be !== 4'b0)  begin miscompares++; $display("[TB] FAIL rst_be got %b exp 0000", bus.dmem_be); end
    vectors++; if (in_ready !== 1'b1)     begin miscompares++; $display("[TB] FAIL rst_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_nonmem_stream();
    for (int i = 1; i <= 4; i++) begin
      in_load = 1'b0; in_store = 1'b0; in_size = 3'b010; in_addr = 32'(i);
      in_rd = 5'(i); in_reg_write = 1'b1; in_valid = 1'b1;
      #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_stall op %0d got %b exp 0", i, stall); end
      step();
      vectors++; if (out_valid !== 1'b1 || out_data !== 32'(i))
        begin miscompares++; $display("[TB] FAIL stream_data op %0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, i); end
    end
    in_valid = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_store_sb();
    obs_t o;
    drive_op(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd3, 1'b1, 0, -1, 32'd0, 1'b0, o);
    vectors++; if (o.lat !== 16'd2)          begin miscompares++; $display("[TB] FAIL sb_latency got %0d exp 2", o.lat); end
    vectors++; if (o.baddr !== 32'h0000_1000) begin miscompares++; $display("[TB] FAIL sb_addr got %h exp 00001000", o.baddr); end
    vectors++; if (o.bbe !== 4'b1000)         begin miscompares++; $display("[TB] FAIL sb_be got %b exp 1000", o.bbe); end
    vectors++; if (o.bwdata !== 32'hABAB_ABAB) begin miscompares++; $display("[TB] FAIL sb_wdata got %h exp ABABABAB", o.bwdata); end
    vectors++; if (o.bwe !== 1'b1)            begin miscompares++; $display("[TB] FAIL sb_we got %b exp 1", o.bwe); end
    vectors++; if (o.data !== 32'd0 || o.rw !== 1'b1 || o.exc !== 1'b0)
      begin miscompares++; $display("[TB] FAIL sb_result got d=%h rw=%b exc=%b exp d=0 rw=1 exc=0", o.data, o.rw, o.exc); end
    step();
  endtask

  task automatic test_load_lh();
    obs_t o;
    drive_op(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 5'd5, 1'b1, 0, 3, 32'h8001_0000, 1'b1, o);
    vectors++; if (o.data !== 32'hFFFF_8001) begin miscompares++; $display("[TB] FAIL lh_data got %h exp FFFF8001", o.data); end
    vectors++; if (o.lat !== 16'd5)          begin miscompares++; $display("[TB] FAIL lh_latency got %0d exp 5", o.lat); end
    vectors++; if (o.stall_cycles !== 16'd4) begin miscompares++; $display("[TB] FAIL lh_stall got %0d cycles exp 4", o.stall_cycles); end
    vectors++; if (o.bbe !== 4'b0000 || o.bwe !== 1'b0 || o.baddr !== 32'h0000_2000)
      begin miscompares++; $display("[TB] FAIL lh_bus got be=%b we=%b a=%h exp be=0000 we=0 a=00002000", o.bbe, o.bwe, o.baddr); end
    vectors++; if (o.rd !== 5'd5 || o.rw !== 1'b1) begin miscompares++; $display("[TB] FAIL lh_rd got rd=%0d rw=%b exp rd=5 rw=1", o.rd, o.rw); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0F0F)
      begin miscompares++; $display("[TB] FAIL lh_follower got v=%b d=%h exp v=1 d=00000F0F", out_valid, out_data); end
    step();
    drive_op(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 5'd6, 1'b1, 0, 3, 32'h8001_0000, 1'b0, o);
    vectors++; if (o.data !== 32'h0000_8001) begin miscompares++; $display("[TB] FAIL lhu_data got %h exp 00008001", o.data); end
    step();
  endtask

  task automatic test_misaligned();
    obs_t o;
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 5'd7, 1'b1, 0, 1, 32'd0, 1'b0, o);
    vectors++; if (o.lat !== 16'd1 || o.req_cycles !== 16'd0)
      begin miscompares++; $display("[TB] FAIL lw_mis_timing got lat=%0d req=%0d exp lat=1 req=0", o.lat, o.req_cycles); end
    vectors++; if (o.exc !== 1'b1 || o.cause !== 2'b01 || o.rw !== 1'b0 || o.data !== 32'h0000_3001)
      begin miscompares++; $display("[TB] FAIL lw_mis_result got exc=%b c=%b rw=%b d=%h exp 1 01 0 00003001", o.exc, o.cause, o.rw, o.data); end
    step();
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_4001, 32'h1234_5678, 5'd8, 1'b1, 0, -1, 32'd0, 1'b0, o);
    vectors++; if (o.exc !== 1'b1 || o.cause !== 2'b10 || o.rw !== 1'b0 || o.req_cycles !== 16'd0)
      begin miscompares++; $display("[TB] FAIL sh_mis got exc=%b c=%b rw=%b req=%0d exp 1 10 0 0", o.exc, o.cause, o.rw, o.req_cycles); end
    step();
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd10, 1'b1, -1, -1, 32'd0, 1'b0, o);
    vectors++; if (o.req_cycles !== 16'(MAX_WAIT)) begin miscompares++; $display("[TB] FAIL to_req_cycles got %0d exp %0d", o.req_cycles, MAX_WAIT); end
    vectors++; if (o.lat !== 16'(MAX_WAIT + 1))    begin miscompares++; $display("[TB] FAIL to_latency got %0d exp %0d", o.lat, MAX_WAIT + 1); end
    vectors++; if (o.exc !== 1'b1 || o.cause !== 2'b11 || o.rw !== 1'b0)
      begin miscompares++; $display("[TB] FAIL to_result got exc=%b c=%b rw=%b exp 1 11 0", o.exc, o.cause, o.rw); end
    step();
    bus.dmem_rvalid = 1'b1;
    step();
    bus.dmem_rvalid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stray_rvalid got out_valid=%b exp 0", out_valid); end
    step();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_5004, 32'd0, 5'd11, 1'b1, 2, -1, 32'd0, 1'b0, o);
    vectors++; if (o.lat !== 16'(MAX_WAIT + 1) || o.cause !== 2'b11 || o.req_cycles !== 16'd3)
      begin miscompares++; $display("[TB] FAIL to_wait got lat=%0d c=%b req=%0d exp %0d 11 3", o.lat, o.cause, o.req_cycles, MAX_WAIT + 1); end
    step();
    drive_op(1'b0, 1'b1, 3'b010, 32'h0000_5008, 32'hCAFE_F00D, 5'd12, 1'b1, MAX_WAIT - 1, -1, 32'd0, 1'b0, o);
    vectors++; if (o.exc !== 1'b0 || o.lat !== 16'(MAX_WAIT + 1) || o.rw !== 1'b1)
      begin miscompares++; $display("[TB] FAIL gnt_wins got exc=%b lat=%0d rw=%b exp 0 %0d 1", o.exc, o.lat, o.rw, MAX_WAIT + 1); end
    step();
  endtask

  task automatic test_backpressure();
    obs_t o;
    out_ready = 1'b0;
    drive_op(1'b0, 1'b0, 3'b010, 32'h0000_0055, 32'd0, 5'd7, 1'b1, 0, -1, 32'd0, 1'b0, o);
    in_load = 1'b0; in_store = 1'b0; in_addr = 32'h0000_0066; in_rd = 5'd8; in_reg_write = 1'b1; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (in_ready !== 1'b0 || stall !== 1'b1)
        begin miscompares++; $display("[TB] FAIL bp_ready cyc %0d got rdy=%b stall=%b exp 0 1", i, in_ready, stall); end
      vectors++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0055 || out_rd !== 5'd7 || out_reg_write !== 1'b1 || out_exc !== 1'b0)
        begin miscompares++; $display("[TB] FAIL bp_hold cyc %0d got v=%b d=%h rd=%0d rw=%b exc=%b", i, out_valid, out_data, out_rd, out_reg_write, out_exc); end
      step();
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release got in_ready=%b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0066 || out_rd !== 5'd8)
      begin miscompares++; $display("[TB] FAIL bp_next got v=%b d=%h rd=%0d exp 1 00000066 8", out_valid, out_data, out_rd); end
    step();
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    in_load = 1'b1; in_store = 1'b0; in_size = 3'b010; in_addr = 32'h0000_0100; in_rd = 5'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (bus.dmem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_req_before got %b exp 1", bus.dmem_req); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (bus.dmem_req !== 1'b0 || in_ready !== 1'b1)
      begin miscompares++; $display("[TB] FAIL mid_req_async got req=%b rdy=%b exp 0 1", bus.dmem_req, in_ready); end
    @(negedge clk) rst = 1'b1;
    step();
    drive_op(1'b0, 1'b0, 3'b010, 32'h0000_0077, 32'd0, 5'd13, 1'b1, 0, -1, 32'd0, 1'b0, o);
    step();
    in_load = 1'b1; in_store = 1'b0; in_size = 3'b010; in_addr = 32'h0000_0200; in_rd = 5'd14; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    step();
    rst = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd0 || out_reg_write !== 1'b0 || out_exc !== 1'b0 || out_exc_cause !== 2'd0)
      begin miscompares++; $display("[TB] FAIL mid_wait_outputs got v=%b d=%h rd=%0d rw=%b exc=%b c=%b", out_valid, out_data, out_rd, out_reg_write, out_exc, out_exc_cause); end
    vectors++; if (bus.dmem_req !== 1'b0 || bus.dmem_be !== 4'b0 || in_ready !== 1'b1)
      begin miscompares++; $display("[TB] FAIL mid_wait_bus got req=%b be=%b rdy=%b", bus.dmem_req, bus.dmem_be, in_ready); end
    @(negedge clk) rst = 1'b1;
    bus.dmem_rvalid = 1'b1;
    step();
    bus.dmem_rvalid = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_discard got out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic ld, st, rw;
    logic [2:0] sz;
    logic [31:0] a, sd, rdata;
    logic [4:0] rd;
    int cls, gd, rv, elat;
    for (int n = 0; n < 40; n++) begin
      cls = int'($urandom_range(0, 2));
      ld = (cls == 1); st = (cls == 2);
      if (st) sz = 3'($urandom_range(0, 2));
      else case ($urandom_range(0, 4))
        0: sz = 3'b000; 1: sz = 3'b001; 2: sz = 3'b010; 3: sz = 3'b100; default: sz = 3'b101;
      endcase
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (sz[1:0] == 2'b01) ? {a[1], 1'b0} : (sz[1:0] == 2'b10) ? 2'b00 : a[1:0];
      sd = $urandom; rdata = $urandom; rd = 5'($urandom); rw = 1'($urandom);
      gd = int'($urandom_range(0, 3)); rv = int'($urandom_range(1, 3));
      e = model(ld, st, sz, a, sd, rdata, rw);
      elat = (!e.mem) ? 1 : st ? gd + 2 : gd + rv + 2;
      drive_op(ld, st, sz, a, sd, rd, rw, gd, rv, rdata, 1'b0, o);
      vectors++; if (o.data !== e.data || o.exc !== e.exc || o.cause !== e.cause || o.rw !== e.rw)
        begin miscompares++; $display("[TB] FAIL rnd%0d_result op=%0d sz=%b a=%h got d=%h exc=%b c=%b rw=%b exp d=%h exc=%b c=%b rw=%b",
                                      n, cls, sz, a, o.data, o.exc, o.cause, o.rw, e.data, e.exc, e.cause, e.rw); end
      vectors++; if (o.lat !== 16'(elat)) begin miscompares++; $display("[TB] FAIL rnd%0d_latency got %0d exp %0d", n, o.lat, elat); end
      if (!e.exc) begin
        vectors++; if (o.rd !== rd) begin miscompares++; $display("[TB] FAIL rnd%0d_rd got %0d exp %0d", n, o.rd, rd); end
      end
      if (e.mem) begin
        vectors++; if (o.baddr !== {a[31:2], 2'b00} || o.bwe !== st || o.bbe !== e.be)
          begin miscompares++; $display("[TB] FAIL rnd%0d_bus got a=%h we=%b be=%b exp a=%h we=%b be=%b", n, o.baddr, o.bwe, o.bbe, {a[31:2], 2'b00}, st, e.be); end
        if (st) begin
          vectors++; if (o.bwdata !== e.wdata) begin miscompares++; $display("[TB] FAIL rnd%0d_wdata got %h exp %h", n, o.bwdata, e.wdata); end
        end
      end else begin
        vectors++; if (o.req_cycles !== 16'd0) begin miscompares++; $display("[TB] FAIL rnd%0d_noreq got %0d req cycles exp 0", n, o.req_cycles); end
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 3'b000;
    in_addr = 32'd0; in_sd = 32'd0; in_rd = 5'd0; in_reg_write = 1'b0;
    out_ready = 1'b1;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;
    test_reset();
    test_nonmem_stream();
    test_store_sb();
    test_load_lh();
    test_misaligned();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
